run_timer_ctrl: RTL and testbench
=================================

// Module: run_timer_ctrl
// PURPOSE
//  Sequences the maze run timer: start, pause/resume, finish, and persistent best (lowest) time.
//  Sits between the button/debounce logic and the maze game logic on one side, and the 7-seg score display on the other.
//  Counts elapsed run time in 0.1 s units only while a run is active.
//  Commits the best time when the maze signals gameover.
// PARAMETERS
//  CLK_FREQ   100000000  input clock frequency, Hz
//  TICK_RATE  10         timer resolution, ticks per second (tick period = CLK_FREQ/TICK_RATE cycles)
//  TIME_W     16         width of elapsed/best time registers
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high reset
//  start       in   1       1-cycle pulse: begin new run (IDLE or DONE only)
//  pause       in   1       1-cycle pulse: toggle RUN<->PAUSE
//  gameover    in   1       level: player reached maze exit
//  clear_best  in   1       1-cycle pulse: forget stored best time
//  state       out  2       00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//  elapsed     out  TIME_W  current/last run time, ticks
//  best        out  TIME_W  best (lowest) completed time; all-ones when none
//  best_valid  out  1       best holds a real completed time
//  new_record  out  1       last completed run set a new best; held until next start/reset
// BEHAVIOUR
//  Reset values:
//   state=IDLE, elapsed=0, best='1, best_valid=0, new_record=0.
//   Prescaler=0.
//  Prescaler:
//   counts 0..CLK_FREQ/TICK_RATE-1 only in RUN; tick asserts on the terminal count, then wraps to 0.
//   Holds its value in PAUSE, so a resumed run loses no partial tick.
//   Cleared on every run start.
//  IDLE:
//   start -> RUN; elapsed<=0; prescaler<=0; new_record<=0.
//   pause and gameover are ignored.
//  RUN:
//   gameover -> DONE. Highest priority: a tick or pause in the same cycle is dropped.
//   else pause -> PAUSE. A tick in the same cycle is still counted.
//   else tick -> elapsed+1, saturating at all-ones (no wrap).
//   start is ignored.
//  PAUSE:
//   gameover -> DONE with no increment.
//   pause -> RUN.
//   start is ignored.
//  DONE:
//   elapsed frozen.
//   start -> RUN (same actions as from IDLE).
//   gameover held high does not re-commit.
//  Commit: happens on the RUN/PAUSE->DONE edge, using the pre-edge value of elapsed.
//   if !best_valid or elapsed < best: best<=elapsed, best_valid<=1, new_record<=1.
//   The update is visible in the same cycle state reads DONE.
//   A tie is not a record.
//  clear_best: any state; best<='1, best_valid<=0; state and elapsed are untouched.
//   Wins over a commit in the same cycle; new_record is still set if the run beat the old best.
//  Reset mid-run: returns to IDLE; best is lost (volatile, by design).
//  All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared package:
//   state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE.
//   Function tick_hit(CLK_FREQ,TICK_RATE).
//  Sub-module tick_prescaler (parameters CLK_FREQ, TICK_RATE)
//   ports: clk, reset, clr, en -> tick.
//  This module holds the FSM, elapsed counter, and best/record registers.
// TESTING  (CLK_FREQ=100, TICK_RATE=10 -> tick every 10 cycles)
//  1 reset, start, run 55 cycles, gameover -> state=DONE, elapsed=5, best=5, best_valid=1, new_record=1.
//  2 start, pause at cycle 25, idle 100 cycles, pause, run 35 more cycles -> elapsed=6; no counting while paused.
//  3 after best=5: run to elapsed=7 then gameover -> best=5, new_record=0.
//    Then run to elapsed=3 -> best=3, new_record=1. A tie (3) -> new_record=0.
//  4 gameover coincident with tick at elapsed=4 -> elapsed stays 4.
//    pause coincident with tick -> increment counted.
//  5 TIME_W=4: run 200 cycles -> elapsed saturates at 15, no wrap.
//    clear_best with commit in same cycle -> best_valid=0, best=15.
//  6 reset asserted in RUN/PAUSE/DONE -> all outputs at reset values next cycle.
//    start/pause/gameover pulses in IDLE other than start -> no state change.

Source files
------------

// File: rtl/run_timer_ctrl_pkg.sv
// Shared definitions for the maze run timer.
//   state_t  : FSM encodings, also the value driven on the 2-bit state output
//   tick_hit : terminal prescaler count for a given clock and tick rate
`timescale 1ns/1ps
package run_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Last count value of the prescaler; the tick fires while sitting on it.
  function automatic int tick_hit(input int clk_freq, input int tick_rate);
    return (clk_freq / tick_rate) - 1;
  endfunction

endpackage

// File: rtl/run_timer_ctrl_tick_prescaler.sv
// Tick prescaler for the run timer.
//   clk, reset : system clock, synchronous active-high reset
//   clr        : restart the count at 0 (run start)
//   en         : advance the count (only while a run is active)
//   tick       : high on the terminal count while enabled
// The count holds while en is low, so a paused run keeps its partial tick.
`timescale 1ns/1ps
module tick_prescaler
  import run_timer_ctrl_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int TICK_RATE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DIV   = CLK_FREQ / TICK_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TERM  = tick_hit(CLK_FREQ, TICK_RATE);

  logic [CNT_W-1:0] count;
  logic             at_term;

  assign at_term = (count == CNT_W'(TERM));
  assign tick    = en && at_term;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      if (at_term) count <= '0;
      else         count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_timer_ctrl.sv
// Maze run timer controller.
//   clk, reset  : system clock, synchronous active-high reset
//   start       : pulse, begin a new run from IDLE or DONE
//   pause       : pulse, toggle RUN <-> PAUSE
//   gameover    : level, player reached the exit; ends RUN/PAUSE
//   clear_best  : pulse, forget the stored best time
//   state       : 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   elapsed     : current/last run time in ticks, saturating
//   best        : lowest completed time, all-ones when none
//   best_valid  : best holds a real completed time
//   new_record  : last completed run beat the stored best
// All outputs come straight from registers.
`timescale 1ns/1ps
module run_timer_ctrl
  import run_timer_ctrl_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int TICK_RATE = 10,
  parameter int TIME_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              gameover,
  input  logic              clear_best,
  output logic [1:0]        state,
  output logic [TIME_W-1:0] elapsed,
  output logic [TIME_W-1:0] best,
  output logic              best_valid,
  output logic              new_record
);

  state_t state_q, state_d;
  logic   run_start;
  logic   commit;
  logic   tick;
  logic   count_tick;
  logic   is_record;

  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  tick_prescaler #(
    .CLK_FREQ  (CLK_FREQ),
    .TICK_RATE (TICK_RATE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (run_start),
    .en    (state_q == ST_RUN),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          run_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (gameover) begin
          state_d = ST_DONE;
          commit  = 1'b1;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (gameover) begin
          state_d = ST_DONE;
          commit  = 1'b1;
        end else if (pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // gameover takes priority over a coincident tick; pause does not.
  assign count_tick = (state_q == ST_RUN) && !gameover && tick;

  // A tie with the stored best is not a record.
  assign is_record = !best_valid || (elapsed < best);

  always_ff @(posedge clk) begin
    if (reset) begin
      elapsed <= '0;
    end else if (run_start) begin
      elapsed <= '0;
    end else if (count_tick) begin
      elapsed <= sat_inc(elapsed);
    end
  end

  // clear_best overrides a commit landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clear_best) begin
      best       <= '1;
      best_valid <= 1'b0;
    end else if (commit && is_record) begin
      best       <= elapsed;
      best_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || run_start) new_record <= 1'b0;
    else if (commit)        new_record <= is_record;
  end

  assign state = state_q;

endmodule

// File: tb/tb_run_timer_ctrl.sv
`timescale 1ns/1ps
module tb_run_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, pause, gameover, clear_best;
  logic [1:0]  state;
  logic [15:0] elapsed, best;
  logic        best_valid, new_record;

  logic        s_start, s_pause, s_gameover, s_clear_best;
  logic [1:0]  s_state;
  logic [3:0]  s_elapsed, s_best;
  logic        s_best_valid, s_new_record;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_timer_ctrl #(.CLK_FREQ(100), .TICK_RATE(10), .TIME_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .gameover(gameover),
    .clear_best(clear_best), .state(state), .elapsed(elapsed), .best(best),
    .best_valid(best_valid), .new_record(new_record)
  );

  run_timer_ctrl #(.CLK_FREQ(100), .TICK_RATE(10), .TIME_W(4)) dut_sat (
    .clk(clk), .reset(reset), .start(s_start), .pause(s_pause), .gameover(s_gameover),
    .clear_best(s_clear_best), .state(s_state), .elapsed(s_elapsed), .best(s_best),
    .best_valid(s_best_valid), .new_record(s_new_record)
  );

  typedef struct {
    logic        s, p, g, c;
    int          n;
    logic [1:0]  st;
    logic [15:0] el, bs;
    logic        bv, nr;
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] el, bs;
    logic        bv, nr;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic s, p, g, c, input int n, input logic [1:0] st,
                              input logic [15:0] el, bs, input logic bv, nr);
    vec_t v;
    v.s = s; v.p = p; v.g = g; v.c = c; v.n = n;
    v.st = st; v.el = el; v.bs = bs; v.bv = bv; v.nr = nr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".state"},      {30'd0, state},      {30'd0, e.st});
    chk({tag, ".elapsed"},    {16'd0, elapsed},    {16'd0, e.el});
    chk({tag, ".best"},       {16'd0, best},       {16'd0, e.bs});
    chk({tag, ".best_valid"}, {31'd0, best_valid}, {31'd0, e.bv});
    chk({tag, ".new_record"}, {31'd0, new_record}, {31'd0, e.nr});
  endtask

  // Drive one cycle of pulses, then idle n cycles; always left on a negedge.
  task automatic apply(input logic s, p, g, c, input int n);
    start = s; pause = p; gameover = g; clear_best = c;
    @(negedge clk);
    start = 1'b0; pause = 1'b0; gameover = 1'b0; clear_best = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  exp_t rst_exp;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0; pause = 1'b0; gameover = 1'b0; clear_best = 1'b0;
    s_start = 1'b0; s_pause = 1'b0; s_gameover = 1'b0; s_clear_best = 1'b0;
    rst_exp.st = 2'b00; rst_exp.el = 16'd0; rst_exp.bs = 16'hFFFF;
    rst_exp.bv = 1'b0; rst_exp.nr = 1'b0;

    //               s  p  g  c   n    st     el  best     bv nr
    tbl.push_back(mk(0, 1, 0, 0,   2, 2'b00,  0, 16'hFFFF, 0, 0)); // pause ignored in IDLE
    tbl.push_back(mk(0, 0, 1, 0,   2, 2'b00,  0, 16'hFFFF, 0, 0)); // gameover ignored in IDLE
    tbl.push_back(mk(1, 0, 0, 0,  55, 2'b01,  5, 16'hFFFF, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,   0, 2'b11,  5, 16'd5,    1, 1)); // first best
    tbl.push_back(mk(0, 0, 1, 0,   3, 2'b11,  5, 16'd5,    1, 1)); // no re-commit in DONE
    tbl.push_back(mk(1, 0, 0, 0,  25, 2'b01,  2, 16'd5,    1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 100, 2'b10,  2, 16'd5,    1, 0)); // frozen while paused
    tbl.push_back(mk(0, 1, 0, 0,  35, 2'b01,  6, 16'd5,    1, 0)); // partial tick kept
    tbl.push_back(mk(0, 0, 1, 0,   0, 2'b11,  6, 16'd5,    1, 0));
    tbl.push_back(mk(1, 0, 0, 0,  70, 2'b01,  7, 16'd5,    1, 0));
    tbl.push_back(mk(0, 0, 1, 0,   0, 2'b11,  7, 16'd5,    1, 0)); // slower: no record
    tbl.push_back(mk(1, 0, 0, 0,  30, 2'b01,  3, 16'd5,    1, 0));
    tbl.push_back(mk(0, 0, 1, 0,   0, 2'b11,  3, 16'd3,    1, 1)); // faster: record
    tbl.push_back(mk(1, 0, 0, 0,  30, 2'b01,  3, 16'd3,    1, 0));
    tbl.push_back(mk(0, 0, 1, 0,   0, 2'b11,  3, 16'd3,    1, 0)); // tie: no record
    tbl.push_back(mk(1, 0, 0, 0,  49, 2'b01,  4, 16'd3,    1, 0)); // prescaler on terminal
    tbl.push_back(mk(0, 0, 1, 0,   0, 2'b11,  4, 16'd3,    1, 0)); // tick dropped by gameover
    tbl.push_back(mk(1, 0, 0, 0,   9, 2'b01,  0, 16'd3,    1, 0));
    tbl.push_back(mk(0, 1, 0, 0,   0, 2'b10,  1, 16'd3,    1, 0)); // tick counted with pause
    tbl.push_back(mk(0, 1, 0, 0,  10, 2'b01,  2, 16'd3,    1, 0));
    tbl.push_back(mk(0, 0, 0, 1,   0, 2'b01,  2, 16'hFFFF, 0, 0)); // clear in RUN
    tbl.push_back(mk(0, 0, 1, 0,   0, 2'b11,  2, 16'd2,    1, 1));
    tbl.push_back(mk(0, 0, 0, 1,   0, 2'b11,  2, 16'hFFFF, 0, 1)); // clear keeps record flag
    tbl.push_back(mk(1, 0, 0, 0,  30, 2'b01,  3, 16'hFFFF, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1,   0, 2'b11,  3, 16'hFFFF, 0, 1)); // clear wins over commit
    tbl.push_back(mk(1, 0, 0, 0,   5, 2'b01,  0, 16'hFFFF, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,   5, 2'b01,  1, 16'hFFFF, 0, 0)); // start ignored in RUN
    tbl.push_back(mk(0, 1, 0, 0,   0, 2'b10,  1, 16'hFFFF, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,   3, 2'b10,  1, 16'hFFFF, 0, 0)); // start ignored in PAUSE
    tbl.push_back(mk(0, 0, 1, 0,   0, 2'b11,  1, 16'd1,    1, 1)); // commit from PAUSE

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_all("reset", rst_exp);

    foreach (tbl[i]) begin
      exp_t e;
      e.st = tbl[i].st; e.el = tbl[i].el; e.bs = tbl[i].bs; e.bv = tbl[i].bv; e.nr = tbl[i].nr;
      exp_q.push_back(e);
      apply(tbl[i].s, tbl[i].p, tbl[i].g, tbl[i].c, tbl[i].n);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: queue empty at vector %0d", i);
      end else begin
        chk_all($sformatf("vec%0d", i), exp_q.pop_front());
      end
    end

    // Saturation with a 4-bit time register.
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (200) @(negedge clk);
    chk("sat.state",   {30'd0, s_state},   32'd1);
    chk("sat.elapsed", {28'd0, s_elapsed}, 32'd15);
    s_gameover = 1'b1; s_clear_best = 1'b1;
    @(negedge clk);
    s_gameover = 1'b0; s_clear_best = 1'b0;
    chk("sat_clr.state",      {30'd0, s_state},      32'd3);
    chk("sat_clr.elapsed",    {28'd0, s_elapsed},    32'd15);
    chk("sat_clr.best",       {28'd0, s_best},       32'd15);
    chk("sat_clr.best_valid", {31'd0, s_best_valid}, 32'd0);
    chk("sat_clr.new_record", {31'd0, s_new_record}, 32'd1);

    // Reset in DONE: best is lost.
    pulse_reset();
    chk_all("rst_done", rst_exp);
    chk("rst_done.sat_state", {30'd0, s_state}, 32'd0);

    // Reset in RUN.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 15);
    chk("pre_rst_run.elapsed", {16'd0, elapsed}, 32'd1);
    pulse_reset();
    chk_all("rst_run", rst_exp);

    // Reset in PAUSE.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 5);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 2);
    chk("pre_rst_pause.state", {30'd0, state}, 32'd2);
    pulse_reset();
    chk_all("rst_pause", rst_exp);

    // A fresh run after reset starts timing from zero.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 20);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("post_rst.elapsed",    {16'd0, elapsed},    32'd2);
    chk("post_rst.best",       {16'd0, best},       32'd2);
    chk("post_rst.new_record", {31'd0, new_record}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
